// File: rtl/rbcp_to_bus_ack_pkg.sv
// Shared types and constants for the RBCP-to-bus bridge and the bus slaves that use its
// wait-state handshake.
package rbcp_to_bus_ack_pkg;

   localparam int RBCP_DW = 8;

   // Slave drives BUS_ACK_REQ to this value in the strobe cycle to request a wait-state.
   localparam logic ACK_REQ_WAIT = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_STROBE   = 3'd1,
      ST_LAT      = 3'd2,
      ST_WAIT_ACK = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   typedef struct packed {
      logic               wr;
      logic [RBCP_DW-1:0] wd;
   } req_t;

   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/rbcp_to_bus_ack_timeout_cnt.sv
// Saturating cycle counter with synchronous clear and a terminal-count compare,
// shared by read-latency counting and wait-state timeout.
module rbcp_to_bus_ack_timeout_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == limit);

endmodule

// File: rtl/rbcp_to_bus_ack.sv
// Registered RBCP-to-bus bridge: one-cycle bus strobes, optional slave wait-states,
// timeout-forced completion so an RBCP transaction can never hang.
module rbcp_to_bus_ack
   import rbcp_to_bus_ack_pkg::*;
#(
   parameter int         ABUSWIDTH    = 32,
   parameter int         READ_LATENCY = 1,
   parameter int         TIMEOUT      = 255,
   parameter logic [7:0] TIMEOUT_RD   = 8'hFF
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RST,
   input  logic                 RBCP_ACT,
   input  logic [31:0]          RBCP_ADDR,
   input  logic [RBCP_DW-1:0]   RBCP_WD,
   input  logic                 RBCP_WE,
   input  logic                 RBCP_RE,
   output logic                 RBCP_ACK,
   output logic [RBCP_DW-1:0]   RBCP_RD,
   output logic                 BUS_WR,
   output logic                 BUS_RD,
   output logic [ABUSWIDTH-1:0] BUS_ADD,
   inout  wire  [RBCP_DW-1:0]   BUS_DATA,
   input  logic                 BUS_ACK_REQ,
   input  logic                 BUS_ACK,
   output logic                 BUSY,
   output logic                 TIMEOUT_ERR
);

   localparam int CNT_W = cnt_width((TIMEOUT > READ_LATENCY) ? TIMEOUT : READ_LATENCY);
   localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   state_t           nxt;
   req_t             req;
   logic             accept;
   logic             timed_out;
   logic             cnt_tc;
   logic             cnt_clr;
   logic             cnt_en;
   logic             drive;
   logic [CNT_W-1:0] cnt_limit;

   assign accept    = (state == ST_IDLE) && RBCP_ACT && (RBCP_WE || RBCP_RE);
   assign cnt_clr   = (state == ST_STROBE);
   assign cnt_en    = (state == ST_LAT) || (state == ST_WAIT_ACK);
   assign cnt_limit = (state == ST_LAT) ? LAT_LAST : WAIT_LAST;

   rbcp_to_bus_ack_timeout_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk   (BUS_CLK),
      .rst   (BUS_RST),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .limit (cnt_limit),
      .tc    (cnt_tc)
   );

   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         state <= ST_IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_comb begin
      nxt = state;
      if ((state != ST_IDLE) && !RBCP_ACT) begin
         nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:     if (accept) nxt = ST_STROBE;
            ST_STROBE: begin
               if (BUS_ACK_REQ == ACK_REQ_WAIT) nxt = ST_WAIT_ACK;
               else if (req.wr)                 nxt = ST_DONE;
               else                             nxt = ST_LAT;
            end
            ST_LAT:      if (cnt_tc) nxt = ST_DONE;
            ST_WAIT_ACK: if (BUS_ACK || cnt_tc) nxt = ST_DONE;
            ST_DONE:     nxt = ST_IDLE;
            default:     nxt = ST_IDLE;
         endcase
      end
   end

   // An aborted session (RBCP_ACT low) must leave RBCP_RD and the error flag untouched.
   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         req       <= '0;
         BUS_ADD   <= '0;
         RBCP_RD   <= '0;
         timed_out <= 1'b0;
      end else begin
         if (accept) begin
            BUS_ADD <= RBCP_ADDR[ABUSWIDTH-1:0];
            req.wr  <= RBCP_WE;
            req.wd  <= RBCP_WD;
         end
         if (state == ST_STROBE) begin
            timed_out <= 1'b0;
         end else if ((state == ST_WAIT_ACK) && RBCP_ACT && !BUS_ACK && cnt_tc) begin
            timed_out <= 1'b1;
         end
         if (RBCP_ACT && !req.wr) begin
            if ((state == ST_LAT) && cnt_tc) begin
               RBCP_RD <= BUS_DATA;
            end else if ((state == ST_WAIT_ACK) && BUS_ACK) begin
               RBCP_RD <= BUS_DATA;
            end else if ((state == ST_WAIT_ACK) && cnt_tc) begin
               RBCP_RD <= TIMEOUT_RD;
            end
         end
      end
   end

   always_comb begin
      BUSY        = (state != ST_IDLE);
      BUS_WR      = (state == ST_STROBE) && req.wr && RBCP_ACT;
      BUS_RD      = (state == ST_STROBE) && !req.wr && RBCP_ACT;
      RBCP_ACK    = (state == ST_DONE) && RBCP_ACT;
      TIMEOUT_ERR = RBCP_ACK && timed_out;
      drive       = req.wr && RBCP_ACT && ((state == ST_STROBE) || (state == ST_WAIT_ACK));
   end

   assign BUS_DATA = drive ? req.wd : {RBCP_DW{1'bz}};

endmodule

// File: tb/tb_rbcp_to_bus_ack.sv
// Bench for rbcp_to_bus_ack: two instances (default latency/timeout, and latency 3 with
// timeout 16) exercised by directed scenarios and randomized transactions.
module tb_rbcp_to_bus_ack;

   logic        clk;
   logic        rst;
   logic        act      [2];
   logic        we       [2];
   logic        re       [2];
   logic        areq_i   [2];
   logic        back_i   [2];
   logic [31:0] addr_i   [2];
   logic [7:0]  wd_i     [2];
   logic        ack_o    [2];
   logic        wr_o     [2];
   logic        rd_o     [2];
   logic        busy_o   [2];
   logic        err_o    [2];
   logic [7:0]  rbcp_rd_o[2];
   logic [31:0] add_o    [2];
   logic        sl_oe    [2];
   logic [7:0]  sl_dat   [2];
   wire  [7:0]  bdat0;
   wire  [7:0]  bdat1;

   int rl_of[2] = '{1, 3};
   int to_of[2] = '{255, 16};

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_rd[2];

   // per-transaction observations
   int         o_stb_cyc, o_stb_cnt, o_ack_cyc, o_ack_last, o_ack_cnt, o_err_cnt, o_idle_cyc;
   logic       o_stb_wr, o_err;
   logic [7:0] o_rd, o_bdat;
   logic [31:0] o_add;

   assign bdat0 = sl_oe[0] ? sl_dat[0] : 8'bz;
   assign bdat1 = sl_oe[1] ? sl_dat[1] : 8'bz;

   rbcp_to_bus_ack u_dut0 (
      .BUS_CLK(clk), .BUS_RST(rst), .RBCP_ACT(act[0]), .RBCP_ADDR(addr_i[0]),
      .RBCP_WD(wd_i[0]), .RBCP_WE(we[0]), .RBCP_RE(re[0]), .RBCP_ACK(ack_o[0]),
      .RBCP_RD(rbcp_rd_o[0]), .BUS_WR(wr_o[0]), .BUS_RD(rd_o[0]), .BUS_ADD(add_o[0]),
      .BUS_DATA(bdat0), .BUS_ACK_REQ(areq_i[0]), .BUS_ACK(back_i[0]), .BUSY(busy_o[0]),
      .TIMEOUT_ERR(err_o[0])
   );

   rbcp_to_bus_ack #(.READ_LATENCY(3), .TIMEOUT(16)) u_dut1 (
      .BUS_CLK(clk), .BUS_RST(rst), .RBCP_ACT(act[1]), .RBCP_ADDR(addr_i[1]),
      .RBCP_WD(wd_i[1]), .RBCP_WE(we[1]), .RBCP_RE(re[1]), .RBCP_ACK(ack_o[1]),
      .RBCP_RD(rbcp_rd_o[1]), .BUS_WR(wr_o[1]), .BUS_RD(rd_o[1]), .BUS_ADD(add_o[1]),
      .BUS_DATA(bdat1), .BUS_ACK_REQ(areq_i[1]), .BUS_ACK(back_i[1]), .BUSY(busy_o[1]),
      .TIMEOUT_ERR(err_o[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [7:0] bdat_of(input int d);
      return (d == 0) ? bdat0 : bdat1;
   endfunction

   task automatic idle_inputs(input int d);
      act[d] = 1'b1; we[d] = 1'b0; re[d] = 1'b0; areq_i[d] = 1'b0;
      back_i[d] = 1'b0; sl_oe[d] = 1'b0; sl_dat[d] = 8'h00;
   endtask

   // Cycle 0 is the cycle in which WE/RE is presented. The slave answers a read with the
   // wanted value only in the cycle where the bridge should sample it, and ~value otherwise;
   // with a wait-state it raises BUS_ACK ack_off cycles after the strobe (0 = never).
   task automatic run_txn(input int d, input bit wr, input bit both, input logic [31:0] addr,
                          input logic [7:0] wd, input logic [7:0] rv, input bit areq,
                          input int ack_off, input int abort_at, input int extra_at);
      int budget;
      budget = to_of[d] + 12;
      o_stb_cyc = -1; o_stb_cnt = 0; o_ack_cyc = -1; o_ack_last = -1; o_ack_cnt = 0;
      o_err_cnt = 0; o_idle_cyc = -1; o_stb_wr = 1'b0; o_err = 1'b0;
      o_rd = 8'h00; o_bdat = 8'h00; o_add = 32'h0;
      @(posedge clk); #1;
      act[d] = 1'b1; addr_i[d] = addr; wd_i[d] = wd; areq_i[d] = areq;
      we[d] = wr; re[d] = !wr || both;
      for (int c = 0; c < budget; c++) begin
         if (c == abort_at) act[d] = 1'b0;
         if (c == extra_at) we[d] = 1'b1;
         back_i[d] = (areq && ack_off > 0 && o_stb_cyc >= 0 && c == o_stb_cyc + ack_off);
         if (!wr && o_stb_cyc >= 0 && c > o_stb_cyc) begin
            sl_oe[d]  = 1'b1;
            sl_dat[d] = ~rv;
            if (areq ? back_i[d] : (c == o_stb_cyc + rl_of[d])) sl_dat[d] = rv;
         end
         @(negedge clk);
         if (wr_o[d] || rd_o[d]) begin
            o_stb_cnt++;
            if (o_stb_cyc < 0) begin
               o_stb_cyc = c; o_stb_wr = wr_o[d]; o_add = add_o[d]; o_bdat = bdat_of(d);
            end
         end
         if (ack_o[d]) begin
            o_ack_cnt++;
            o_ack_last = c;
            if (o_ack_cyc < 0) begin
               o_ack_cyc = c; o_rd = rbcp_rd_o[d]; o_err = err_o[d];
            end
         end
         if (err_o[d]) o_err_cnt++;
         if (c >= 1 && !busy_o[d] && o_idle_cyc < 0) o_idle_cyc = c;
         if (o_ack_last >= 0 && c >= o_ack_last + 2 && c >= extra_at + 4) break;
         if (abort_at >= 0 && c >= abort_at + 3) break;
         @(posedge clk); #1;
         we[d] = 1'b0; re[d] = 1'b0;
      end
      idle_inputs(d);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         idle_inputs(d); addr_i[d] = 32'h0; wd_i[d] = 8'h0;
      end
      we[0] = 1'b1; re[1] = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if ({ack_o[d], wr_o[d], rd_o[d], busy_o[d], err_o[d]} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctl[%0d]: ack/wr/rd/busy/err got %b want 00000", d,
                     {ack_o[d], wr_o[d], rd_o[d], busy_o[d], err_o[d]});
         end
         n_cmp++;
         if (add_o[d] !== 32'h0 || rbcp_rd_o[d] !== 8'h0) begin
            n_bad++;
            $display("FAIL reset_dat[%0d]: add %h rd %h want 0 0", d, add_o[d], rbcp_rd_o[d]);
         end
         exp_rd[d] = 8'h00;
      end
      we[0] = 1'b0; re[1] = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_write();
      run_txn(0, 1'b1, 1'b0, 32'h0000_1234, 8'h5A, 8'h00, 1'b0, 0, -1, -1);
      n_cmp++;
      if (o_stb_cyc !== 1 || o_stb_wr !== 1'b1 || o_stb_cnt !== 1) begin
         n_bad++;
         $display("FAIL wr_strobe: cyc %0d wr %b cnt %0d want 1 1 1", o_stb_cyc, o_stb_wr, o_stb_cnt);
      end
      n_cmp++;
      if (o_bdat !== 8'h5A || o_add !== 32'h0000_1234) begin
         n_bad++;
         $display("FAIL wr_bus: data %h add %h want 5a 00001234", o_bdat, o_add);
      end
      n_cmp++;
      if (o_ack_cyc !== 2 || o_ack_cnt !== 1 || o_idle_cyc !== 3) begin
         n_bad++;
         $display("FAIL wr_ack: cyc %0d cnt %0d idle %0d want 2 1 3", o_ack_cyc, o_ack_cnt, o_idle_cyc);
      end
      // both WE and RE high: the write takes precedence
      run_txn(1, 1'b1, 1'b1, 32'h0000_0042, 8'h3C, 8'h00, 1'b0, 0, -1, -1);
      n_cmp++;
      if (o_stb_wr !== 1'b1 || o_bdat !== 8'h3C || o_ack_cyc !== 2) begin
         n_bad++;
         $display("FAIL we_wins: wr %b data %h ack %0d want 1 3c 2", o_stb_wr, o_bdat, o_ack_cyc);
      end
   endtask

   task automatic test_read();
      run_txn(0, 1'b0, 1'b0, 32'h0000_0010, 8'h00, 8'hC3, 1'b0, 0, -1, -1);
      n_cmp++;
      if (o_stb_cyc !== 1 || o_stb_wr !== 1'b0 || o_add !== 32'h10) begin
         n_bad++;
         $display("FAIL rd_strobe: cyc %0d wr %b add %h want 1 0 10", o_stb_cyc, o_stb_wr, o_add);
      end
      n_cmp++;
      if (o_ack_cyc !== 3 || o_rd !== 8'hC3) begin
         n_bad++;
         $display("FAIL rd_lat1: ack %0d data %h want 3 c3", o_ack_cyc, o_rd);
      end
      exp_rd[0] = 8'hC3;
      run_txn(1, 1'b0, 1'b0, 32'h0000_0020, 8'h00, 8'hA5, 1'b0, 0, -1, -1);
      n_cmp++;
      if (o_ack_cyc !== 5 || o_rd !== 8'hA5 || o_ack_cnt !== 1) begin
         n_bad++;
         $display("FAIL rd_lat3: ack %0d data %h cnt %0d want 5 a5 1", o_ack_cyc, o_rd, o_ack_cnt);
      end
      exp_rd[1] = 8'hA5;
   endtask

   task automatic test_wait_ack();
      run_txn(0, 1'b0, 1'b0, 32'h0000_0030, 8'h00, 8'h77, 1'b1, 10, -1, -1);
      n_cmp++;
      if (o_ack_cyc !== 12 || o_rd !== 8'h77 || o_err_cnt !== 0) begin
         n_bad++;
         $display("FAIL wait_ack: ack %0d data %h errs %0d want 12 77 0", o_ack_cyc, o_rd, o_err_cnt);
      end
      exp_rd[0] = 8'h77;
   endtask

   task automatic test_timeout();
      // BUS_ACK in the last allowed wait cycle still completes normally
      run_txn(1, 1'b0, 1'b0, 32'h0000_0044, 8'h00, 8'h19, 1'b1, 16, -1, -1);
      n_cmp++;
      if (o_ack_cyc !== 18 || o_rd !== 8'h19 || o_err_cnt !== 0) begin
         n_bad++;
         $display("FAIL to_edge_ok: ack %0d data %h errs %0d want 18 19 0", o_ack_cyc, o_rd, o_err_cnt);
      end
      run_txn(1, 1'b0, 1'b0, 32'h0000_0045, 8'h00, 8'h19, 1'b1, 0, -1, -1);
      n_cmp++;
      if (o_ack_cyc !== 18 || o_err !== 1'b1 || o_err_cnt !== 1 || o_rd !== 8'hFF) begin
         n_bad++;
         $display("FAIL to_read: ack %0d err %b errs %0d data %h want 18 1 1 ff",
                  o_ack_cyc, o_err, o_err_cnt, o_rd);
      end
      exp_rd[1] = 8'hFF;
      run_txn(0, 1'b1, 1'b0, 32'h0000_0046, 8'h81, 8'h00, 1'b1, 0, -1, -1);
      n_cmp++;
      if (o_ack_cyc !== 257 || o_err !== 1'b1 || o_rd !== exp_rd[0]) begin
         n_bad++;
         $display("FAIL to_write: ack %0d err %b data %h want 257 1 %h", o_ack_cyc, o_err, o_rd, exp_rd[0]);
      end
   endtask

   task automatic test_abort();
      run_txn(0, 1'b0, 1'b0, 32'h0000_0050, 8'h00, 8'h66, 1'b1, 0, 5, -1);
      n_cmp++;
      if (o_ack_cnt !== 0 || o_err_cnt !== 0 || o_idle_cyc !== 6) begin
         n_bad++;
         $display("FAIL abort: acks %0d errs %0d idle %0d want 0 0 6", o_ack_cnt, o_err_cnt, o_idle_cyc);
      end
      @(negedge clk);
      n_cmp++;
      if (rbcp_rd_o[0] !== exp_rd[0]) begin
         n_bad++;
         $display("FAIL abort_rd: got %h want %h", rbcp_rd_o[0], exp_rd[0]);
      end
   endtask

   task automatic test_busy_we();
      run_txn(0, 1'b1, 1'b0, 32'h0000_0060, 8'h11, 8'h00, 1'b1, 4, -1, 3);
      n_cmp++;
      if (o_ack_cnt !== 1 || o_stb_cnt !== 1 || o_ack_cyc !== 6) begin
         n_bad++;
         $display("FAIL busy_we: acks %0d strobes %0d ack %0d want 1 1 6", o_ack_cnt, o_stb_cnt, o_ack_cyc);
      end
   endtask

   task automatic test_back_to_back();
      run_txn(0, 1'b1, 1'b0, 32'h0000_0070, 8'h22, 8'h00, 1'b0, 0, -1, 3);
      n_cmp++;
      if (o_ack_cnt !== 2 || o_stb_cnt !== 2 || o_ack_cyc !== 2 || o_ack_last !== 5) begin
         n_bad++;
         $display("FAIL back_to_back: acks %0d strobes %0d first %0d last %0d want 2 2 2 5",
                  o_ack_cnt, o_stb_cnt, o_ack_cyc, o_ack_last);
      end
   endtask

   task automatic test_reset_mid();
      int acks;
      acks = 0;
      @(posedge clk); #1;
      addr_i[1] = 32'h0000_0080; re[1] = 1'b1;
      @(posedge clk); #1;
      re[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (busy_o[1] !== 1'b0 || rbcp_rd_o[1] !== 8'h00 || add_o[1] !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_mid: busy %b rd %h add %h want 0 00 0", busy_o[1], rbcp_rd_o[1], add_o[1]);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
      repeat (8) begin
         @(negedge clk);
         if (ack_o[1] || busy_o[1]) acks++;
      end
      n_cmp++;
      if (acks !== 0) begin
         n_bad++;
         $display("FAIL reset_mid_ack: ack/busy cycles %0d want 0", acks);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         int d, ack_off, done;
         bit wr, both, areq, err;
         logic [31:0] addr;
         logic [7:0] wd, rv, want_rd;
         d       = $urandom_range(1, 0);
         wr      = $urandom_range(1, 0);
         both    = wr && ($urandom_range(3, 0) == 0);
         areq    = $urandom_range(1, 0);
         ack_off = (d == 0) ? $urandom_range(12, 1) : $urandom_range(18, 0);
         addr    = $urandom;
         wd      = $urandom_range(255, 0);
         rv      = $urandom_range(255, 0);
         // reference: strobe in cycle 1; wait-state lasts at most TIMEOUT cycles
         err = 1'b0;
         if (areq) begin
            if (ack_off >= 1 && ack_off <= to_of[d]) done = 1 + ack_off + 1;
            else begin done = 1 + to_of[d] + 1; err = 1'b1; end
         end else begin
            done = wr ? 2 : 2 + rl_of[d];
         end
         want_rd = wr ? exp_rd[d] : (err ? 8'hFF : rv);
         run_txn(d, wr, both, addr, wd, rv, areq, ack_off, -1, -1);
         n_cmp++;
         if (o_ack_cnt !== 1 || o_ack_cyc !== done || o_idle_cyc !== done + 1) begin
            n_bad++;
            $display("FAIL rnd%0d_ack: cnt %0d cyc %0d idle %0d want 1 %0d %0d",
                     i, o_ack_cnt, o_ack_cyc, o_idle_cyc, done, done + 1);
         end
         n_cmp++;
         if (o_err_cnt !== int'(err) || o_err !== err) begin
            n_bad++;
            $display("FAIL rnd%0d_err: errs %0d at_ack %b want %0d", i, o_err_cnt, o_err, err);
         end
         n_cmp++;
         if (o_rd !== want_rd) begin
            n_bad++;
            $display("FAIL rnd%0d_rd: got %h want %h", i, o_rd, want_rd);
         end
         n_cmp++;
         if (o_stb_cnt !== 1 || o_stb_cyc !== 1 || o_stb_wr !== wr || o_add !== addr) begin
            n_bad++;
            $display("FAIL rnd%0d_strobe: cnt %0d cyc %0d wr %b add %h want 1 1 %b %h",
                     i, o_stb_cnt, o_stb_cyc, o_stb_wr, o_add, wr, addr);
         end
         if (wr) begin
            n_cmp++;
            if (o_bdat !== wd) begin
               n_bad++;
               $display("FAIL rnd%0d_wdata: got %h want %h", i, o_bdat, wd);
            end
         end
         exp_rd[d] = want_rd;
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_wait_ack();
      test_timeout();
      test_abort();
      test_busy_we();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
